// File: rtl/alu_issue_stage.sv
// Decode/operand/writeback stage around a combinational ALU; owns the 16x16 register file and the PSR.
// Latency: operands registered on transfer, ALU result written back on the following edge.
// Backpressure: hold freezes every register; instr_ready = ~hold, with forwarding so dependent ops never stall.
module alu_issue_stage #(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5,
  parameter int NUM_REGS     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  input  logic [15:0]             instr,
  output logic                    instr_ready,
  input  logic                    hold,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic [BIT_WIDTH-1:0]    alu_rdest,
  output logic [BIT_WIDTH-1:0]    alu_rsrc_imm,
  input  logic [BIT_WIDTH-1:0]    alu_result,
  input  logic [FLAG_WIDTH-1:0]   alu_flags,
  output logic [FLAG_WIDTH-1:0]   psr,
  output logic                    illegal,
  input  logic [3:0]              dbg_addr,
  output logic [BIT_WIDTH-1:0]    dbg_data,
  output logic [15:0]             retired
);

  typedef enum logic [2:0] {
    CLS_NOP, CLS_ILL, CLS_SARITH, CLS_UARITH, CLS_CMP, CLS_LOGIC
  } cls_e;

  logic [BIT_WIDTH-1:0] regs [NUM_REGS];

  logic [3:0]           dec_h, dec_d, dec_x, dec_s;
  cls_e                 dec_cls;
  logic                 dec_use_imm;
  logic [BIT_WIDTH-1:0] dec_imm;
  logic [BIT_WIDTH-1:0] rd_d, rd_s;

  logic                  ex_vld;
  logic [3:0]            ex_d;
  cls_e                  ex_cls;
  logic                  ex_wr;
  logic [FLAG_WIDTH-1:0] psr_mask;
  logic                  transfer;

  assign dec_h = instr[15:12];
  assign dec_d = instr[11:8];
  assign dec_x = instr[7:4];
  assign dec_s = instr[3:0];

  assign instr_ready = ~hold;
  assign transfer    = instr_valid & instr_ready;

  always_comb begin
    dec_cls     = CLS_ILL;
    dec_use_imm = 1'b0;
    dec_imm     = '0;
    case (dec_h)
      4'h0: begin
        case (dec_x)
          4'h0:                   dec_cls = CLS_NOP;
          4'h1, 4'h2, 4'h3, 4'h4: dec_cls = CLS_LOGIC;
          4'h5, 4'h7, 4'h9:       dec_cls = CLS_SARITH;
          4'h6:                   dec_cls = CLS_UARITH;
          4'hB:                   dec_cls = CLS_CMP;
          default:                dec_cls = CLS_ILL;
        endcase
      end
      4'h5, 4'h7, 4'h9: begin
        dec_cls     = CLS_SARITH;
        dec_use_imm = 1'b1;
        dec_imm     = {{(BIT_WIDTH-8){instr[7]}}, instr[7:0]};
      end
      4'h6: begin
        dec_cls     = CLS_UARITH;
        dec_use_imm = 1'b1;
        dec_imm     = {{(BIT_WIDTH-8){1'b0}}, instr[7:0]};
      end
      4'hB: begin
        dec_cls     = CLS_CMP;
        dec_use_imm = 1'b1;
        dec_imm     = {{(BIT_WIDTH-8){instr[7]}}, instr[7:0]};
      end
      4'h8: begin
        // Shift-immediate amount is the signed 5-bit field {X[0],S}.
        if (dec_x[3:1] == 3'b000 || dec_x[3:1] == 3'b001 || dec_x[3:1] == 3'b101) begin
          dec_cls     = CLS_LOGIC;
          dec_use_imm = 1'b1;
          dec_imm     = {{(BIT_WIDTH-5){dec_x[0]}}, dec_x[0], dec_s};
        end else if (dec_x == 4'h4 || dec_x == 4'h6 || dec_x == 4'h8 || dec_x == 4'h9) begin
          dec_cls = CLS_LOGIC;
        end
      end
      default: dec_cls = CLS_ILL;
    endcase
  end

  assign ex_wr = ex_vld && (ex_cls == CLS_SARITH || ex_cls == CLS_UARITH || ex_cls == CLS_LOGIC);

  // The in-flight result bypasses the register file for back-to-back dependencies.
  assign rd_d     = (ex_wr && ex_d == dec_d)    ? alu_result : regs[dec_d];
  assign rd_s     = (ex_wr && ex_d == dec_s)    ? alu_result : regs[dec_s];
  assign dbg_data = (ex_wr && ex_d == dbg_addr) ? alu_result : regs[dbg_addr];

  always_comb begin
    psr_mask = '0;
    case (ex_cls)
      CLS_SARITH:         psr_mask = FLAG_WIDTH'(5'b00111);
      CLS_UARITH:         psr_mask = FLAG_WIDTH'(5'b11010);
      CLS_CMP, CLS_LOGIC: psr_mask = FLAG_WIDTH'(5'b00011);
      default:            psr_mask = '0;
    endcase
  end

  assign illegal = ex_vld && (ex_cls == CLS_ILL) && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld       <= 1'b0;
      ex_d         <= '0;
      ex_cls       <= CLS_NOP;
      alu_opcode   <= '0;
      alu_rdest    <= '0;
      alu_rsrc_imm <= '0;
      psr          <= '0;
      retired      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (!hold) begin
      if (transfer) begin
        ex_vld       <= 1'b1;
        ex_d         <= dec_d;
        ex_cls       <= dec_cls;
        alu_opcode   <= (dec_cls == CLS_ILL) ? '0 : OPCODE_WIDTH'({dec_h, dec_x});
        alu_rdest    <= rd_d;
        alu_rsrc_imm <= dec_use_imm ? dec_imm : rd_s;
      end else begin
        ex_vld     <= 1'b0;
        ex_cls     <= CLS_NOP;
        alu_opcode <= '0;
      end
      if (ex_wr) regs[ex_d] <= alu_result;
      if (ex_vld) psr <= (psr & ~psr_mask) | (alu_flags & psr_mask);
      if (ex_vld && ex_cls != CLS_NOP && ex_cls != CLS_ILL) retired <= retired + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: stub ALU, program-order reference model, directed then random stimulus.
module tb_alu_issue_stage;

  localparam int K_NOP = 0, K_S = 1, K_U = 2, K_CMP = 3, K_LOG = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        hold;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_rdest, alu_rsrc_imm, alu_result;
  logic [4:0]  alu_flags, psr;
  logic        illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data, retired;

  int vectors = 0;
  int errors  = 0;

  // Model state: m_reg is program-order (includes the op in flight), psr/retired are committed.
  logic [15:0] m_reg [16];
  logic [4:0]  m_psr, p_psr;
  logic [15:0] m_ret, p_ret;
  bit          p_vld, p_ill, m_ex;
  logic [7:0]  e_op;
  logic [15:0] e_rd, e_rs;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .hold(hold), .alu_opcode(alu_opcode),
    .alu_rdest(alu_rdest), .alu_rsrc_imm(alu_rsrc_imm), .alu_result(alu_result),
    .alu_flags(alu_flags), .psr(psr), .illegal(illegal), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .retired(retired)
  );

  // Stand-in ALU: returns {C,L,F,Z,N,result}.
  function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [3:0]  h, x;
    logic [16:0] sum;
    logic [15:0] r;
    logic        c, l, f, z, n, is_cmp;
    h = op[7:4];
    x = op[3:0];
    sum = {1'b0, a} + {1'b0, b};
    is_cmp = (h == 4'hB) || (h == 4'h0 && x == 4'hB);
    if ((h == 4'h0 && (x == 4'h5 || x == 4'h6 || x == 4'h7)) || h == 4'h5 || h == 4'h6 || h == 4'h7)
      r = sum[15:0];
    else if (is_cmp || h == 4'h9 || (h == 4'h0 && x == 4'h9)) r = a - b;
    else if (h == 4'h8) r = a << b[3:0];
    else if (h == 4'h0) r = a ^ b;
    else r = 16'h0;
    c = sum[16];
    l = (a < b);
    f = (a[15] == b[15]) && (sum[15] != a[15]);
    z = (r == 16'h0);
    n = is_cmp ? ($signed(a) < $signed(b)) : r[15];
    return {c, l, f, z, n, r};
  endfunction

  logic [20:0] alu_out;
  always_comb alu_out = alu_fn(alu_opcode, alu_rdest, alu_rsrc_imm);
  assign alu_result = alu_out[15:0];
  assign alu_flags  = alu_out[20:16];

  task automatic mdecode(input logic [15:0] ins, output int kind, output bit legal,
                         output bit imm_form, output logic [15:0] immv);
    logic [3:0] h, x, s;
    h = ins[15:12]; x = ins[7:4]; s = ins[3:0];
    kind = K_NOP; legal = 1'b1; imm_form = 1'b0; immv = 16'h0;
    if (h == 4'h0) begin
      if (x == 4'h0) kind = K_NOP;
      else if (x >= 4'h1 && x <= 4'h4) kind = K_LOG;
      else if (x == 4'h5 || x == 4'h7 || x == 4'h9) kind = K_S;
      else if (x == 4'h6) kind = K_U;
      else if (x == 4'hB) kind = K_CMP;
      else legal = 1'b0;
    end else if (h inside {4'h5, 4'h7, 4'h9, 4'hB}) begin
      kind = (h == 4'hB) ? K_CMP : K_S;
      imm_form = 1'b1;
      immv = 16'($signed(ins[7:0]));
    end else if (h == 4'h6) begin
      kind = K_U; imm_form = 1'b1; immv = {8'h00, ins[7:0]};
    end else if (h == 4'h8) begin
      if (x inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hA, 4'hB}) begin
        kind = K_LOG; imm_form = 1'b1; immv = 16'($signed({x[0], s}));
      end else if (x inside {4'h4, 4'h6, 4'h8, 4'h9}) kind = K_LOG;
      else legal = 1'b0;
    end else legal = 1'b0;
  endtask

  function automatic logic [4:0] mask_of(input int kind);
    case (kind)
      K_S:          return 5'b00111;
      K_U:          return 5'b11010;
      K_CMP, K_LOG: return 5'b00011;
      default:      return 5'b00000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0;
    m_psr = 5'h0; m_ret = 16'h0; p_vld = 1'b0; p_ill = 1'b0; m_ex = 1'b0;
    e_op = 8'h0; e_rd = 16'h0; e_rs = 16'h0; p_psr = 5'h0; p_ret = 16'h0;
  endtask

  // One clock: advance the model at the edge, then compare every observable output.
  task automatic cycle();
    int          kind;
    bit          legal, imm_form;
    logic [15:0] immv, a, b;
    logic [20:0] fr;
    logic [4:0]  mk;
    @(posedge clk);
    if (!hold) begin
      if (p_vld) begin m_psr = p_psr; m_ret = p_ret; p_vld = 1'b0; end
      if (instr_valid) begin
        mdecode(instr, kind, legal, imm_form, immv);
        a = m_reg[instr[11:8]];
        b = imm_form ? immv : m_reg[instr[3:0]];
        e_op = legal ? instr[15:12] * 8'd16 + {4'h0, instr[7:4]} : 8'h00;
        e_rd = a; e_rs = b; m_ex = 1'b1;
        fr = alu_fn(e_op, a, b);
        mk = legal ? mask_of(kind) : 5'b0;
        p_vld = 1'b1; p_ill = !legal;
        p_psr = (m_psr & ~mk) | (fr[20:16] & mk);
        p_ret = m_ret + ((legal && kind != K_NOP) ? 16'd1 : 16'd0);
        if (legal && (kind == K_S || kind == K_U || kind == K_LOG)) m_reg[instr[11:8]] = fr[15:0];
      end else begin
        e_op = 8'h00; m_ex = 1'b0;
      end
    end
    #1;
    chk("instr_ready", 32'(instr_ready), 32'(!hold));
    chk("psr", 32'(psr), 32'(m_psr));
    chk("retired", 32'(retired), 32'(m_ret));
    chk("alu_opcode", 32'(alu_opcode), 32'(e_op));
    chk("illegal", 32'(illegal), 32'(p_vld && p_ill && !hold));
    chk("dbg_data", 32'(dbg_data), 32'(m_reg[dbg_addr]));
    if (m_ex && !p_ill) begin
      chk("alu_rdest", 32'(alu_rdest), 32'(e_rd));
      chk("alu_rsrc_imm", 32'(alu_rsrc_imm), 32'(e_rs));
    end
  endtask

  task automatic issue(input logic [15:0] ins);
    instr_valid = 1'b1; instr = ins; hold = 1'b0; dbg_addr = 4'($urandom_range(0, 15));
    cycle();
  endtask

  task automatic idle();
    instr_valid = 1'b0; hold = 1'b0;
    cycle();
  endtask

  task automatic peek_reg(input string tag, input logic [3:0] r, input logic [15:0] exp);
    dbg_addr = r;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_psr"}, 32'(psr), 32'h0);
    chk({tag, "_retired"}, 32'(retired), 32'h0);
    chk({tag, "_opcode"}, 32'(alu_opcode), 32'h0);
    chk({tag, "_rdest"}, 32'(alu_rdest), 32'h0);
    chk({tag, "_rsrc"}, 32'(alu_rsrc_imm), 32'h0);
    chk({tag, "_illegal"}, 32'(illegal), 32'h0);
    chk({tag, "_dbg_r1"}, 32'(dbg_data), 32'h0);
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] v;
    logic [3:0]  hs [7] = '{4'h0, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB};
    v = 16'($urandom);
    if ($urandom_range(0, 9) != 0) v[15:12] = hs[$urandom_range(0, 6)];
    if (v[15:12] == 4'h0 && $urandom_range(0, 3) != 0) v[7:4] = 4'($urandom_range(0, 7));
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0; hold = 1'b0; dbg_addr = 4'd1;
    model_reset();
    #2;
    reset_checks("por");
    @(negedge clk); rst_n = 1'b1;
    #1 chk("ready_after_reset", 32'(instr_ready), 32'h1);

    // ADDI R1,#-3 then ADDI R1,#5 back-to-back: second issue forwards 0xFFFD.
    issue(16'h51FD);
    issue(16'h5105);
    chk("fwd_rdest", 32'(alu_rdest), 32'hFFFD);
    idle();
    peek_reg("r1_after_addi", 4'd1, 16'h0002);
    chk("psr_after_addi", 32'(psr), 32'h00);

    // Build R2 = 0xFF01, then ADDUI R2,#0xFF wraps to 0 with carry.
    issue(16'h5280); issue(16'h5280); issue(16'h5201); idle();
    peek_reg("r2_ff01", 4'd2, 16'hFF01);
    issue(16'h62FF); idle();
    peek_reg("r2_addui", 4'd2, 16'h0000);
    chk("psr_addui", 32'(psr), 32'h13);

    // CMP R3,R4 (H=0 D=3 X=B S=4) with R3=5, R4=9.
    issue(16'h5305); issue(16'h5409); idle();
    issue(16'h03B4); idle();
    peek_reg("r3_after_cmp", 4'd3, 16'h0005);
    chk("psr_cmp_zn", 32'(psr[1:0]), 32'h1);
    chk("retired_cmp", 32'(retired), 32'd9);

    // ADD R3,R4 held in execute for three cycles with a competing request pending.
    issue(16'h0354);
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1; instr = 16'h5105; hold = 1'b1;
      cycle();
      chk("hold_opcode", 32'(alu_opcode), 32'h05);
      chk("hold_retired", 32'(retired), 32'd9);
    end
    idle();
    chk("retired_after_hold", 32'(retired), 32'd10);
    peek_reg("r3_after_hold", 4'd3, 16'h000E);

    // Undecodable H=0 X=F targeting R1.
    issue(16'h01FA);
    chk("illegal_opcode", 32'(alu_opcode), 32'h00);
    chk("illegal_pulse", 32'(illegal), 32'h1);
    idle();
    chk("illegal_gone", 32'(illegal), 32'h0);
    chk("illegal_retired", 32'(retired), 32'd10);
    peek_reg("r1_after_illegal", 4'd1, 16'h0002);

    issue(16'h5007); idle();
    peek_reg("r0_write", 4'd0, 16'h0007);

    for (int i = 0; i < 400; i++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      instr = rand_instr();
      hold = ($urandom_range(0, 5) == 0);
      dbg_addr = 4'($urandom_range(0, 15));
      cycle();
    end
    idle(); idle();

    // Asynchronous reset with a write still in flight.
    issue(16'h5101);
    #3 rst_n = 1'b0;
    dbg_addr = 4'd1;
    #1;
    reset_checks("midop");
    model_reset();
    instr_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    idle(); idle();
    peek_reg("r1_discarded", 4'd1, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
